// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller:
// FSM state encoding and the decoded comparator verdict.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

  typedef enum logic [1:0] {
    EQ  = 2'd0,
    GT  = 2'd1,
    LT  = 2'd2,
    BAD = 2'd3
  } cmp_verdict_t;

  // Collapse the three comparator flags into a verdict; anything that is
  // not exactly one-hot is treated as a broken comparator.
  function automatic cmp_verdict_t decode_verdict(input logic eq,
                                                  input logic gt,
                                                  input logic lt);
    cmp_verdict_t v;
    case ({eq, gt, lt})
      3'b100:  v = EQ;
      3'b010:  v = GT;
      3'b001:  v = LT;
      default: v = BAD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sar_settle_cnt.sv
// Settle timer: reloaded with SETTLE whenever a new guess is presented and
// counts down; the strobe marks the cycle on which the comparator flags
// have had SETTLE cycles to settle and may be sampled.
module sar_settle_cnt
  import sar_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic strobe
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE);

  logic [CW-1:0] count;

  // Down-counter that parks at zero until the next guess reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign strobe = (count == '0);

endmodule

// File: rtl/sar_search.sv
// Binary-search controller in front of a magnitude comparator. It drives
// the comparator's a operand with a guess, reads back eq/gt/lt against a
// hidden target and narrows [lo, hi] until the target is found, the range
// is exhausted, or the comparator reports a non one-hot verdict.
module sar_search
  import sar_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int SETTLE = 1,
  localparam int PW     = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [PW-1:0]    probes
);

  // Bounds carry one extra bit so hi can reach -1 and lo can reach 2^WIDTH.
  localparam logic [WIDTH:0] MAX_BOUND = {1'b0, {WIDTH{1'b1}}};

  sar_state_t       state, state_n;
  logic [WIDTH:0]   lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0] guess_n, result_n;
  logic             busy_n, done_n, found_n, error_n;
  logic [PW-1:0]    probes_n;

  cmp_verdict_t     verdict;
  logic [WIDTH:0]   next_lo, next_hi;
  logic             exhausted;
  logic             cnt_load;
  logic             settle_strobe;

  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l,
                                                input logic [WIDTH:0] h);
    logic [WIDTH:0] m;
    m = l + ((h - l) >> 1);
    return m[WIDTH-1:0];
  endfunction

  sar_settle_cnt #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .strobe (settle_strobe)
  );

  // Candidate bounds after the current verdict and whether the range is empty.
  // lo never goes negative and hi never exceeds 2^WIDTH-1, so lo is
  // zero-extended and hi sign-extended before the signed compare; this keeps
  // lo = 2^WIDTH from aliasing to a negative number.
  always_comb begin
    verdict = decode_verdict(cmp_eq, cmp_gt, cmp_lt);
    next_lo = lo;
    next_hi = hi;
    if (verdict == GT) begin
      next_hi = {1'b0, guess} - 1'b1;
    end
    if (verdict == LT) begin
      next_lo = {1'b0, guess} + 1'b1;
    end
    exhausted = $signed({1'b0, next_lo}) > $signed({next_hi[WIDTH], next_hi});
  end

  // Next-state and next-output logic for the search FSM.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    busy_n   = busy;
    done_n   = done;
    found_n  = found;
    error_n  = error;
    result_n = result;
    probes_n = probes;
    cnt_load = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = MAX_BOUND;
          guess_n  = midpoint('0, MAX_BOUND);
          probes_n = '0;
          busy_n   = 1'b1;
          done_n   = 1'b0;
          found_n  = 1'b0;
          error_n  = 1'b0;
          result_n = '0;
          cnt_load = 1'b1;
          state_n  = PROBE;
        end
      end

      PROBE: begin
        if (settle_strobe) begin
          probes_n = probes + 1'b1;
          case (verdict)
            EQ: begin
              found_n  = 1'b1;
              result_n = guess;
              busy_n   = 1'b0;
              done_n   = 1'b1;
              state_n  = DONE;
            end
            GT, LT: begin
              if (exhausted) begin
                found_n = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = DONE;
              end else begin
                lo_n     = next_lo;
                hi_n     = next_hi;
                guess_n  = midpoint(next_lo, next_hi);
                cnt_load = 1'b1;
              end
            end
            default: begin
              error_n = 1'b1;
              found_n = 1'b0;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end
          endcase
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      probes <= '0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      busy   <= busy_n;
      done   <= done_n;
      found  <= found_n;
      error  <= error_n;
      result <= result_n;
      probes <= probes_n;
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=8, SETTLE=1). A behavioural
// comparator answers against a target, or is forced to always-gt or to an
// illegal gt+lt pattern. Expected guess sequences are hand-derived.
module tb_sar_search;
  import sar_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] guess;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic       busy, done, found, error;
  logic [7:0] result;
  logic [3:0] probes;

  logic [7:0] target;
  int         mode;
  int         exp_guess [0:8];
  int         n_asserts = 0;
  int         n_fail    = 0;

  sar_search #(
    .WIDTH  (8),
    .SETTLE (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .guess  (guess),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .error  (error),
    .result (result),
    .probes (probes)
  );

  always #5 clk = ~clk;

  // mode 0: honest comparator, mode 1: always gt, mode 2: gt and lt together
  assign cmp_eq = (mode == 0) && (guess == target);
  assign cmp_gt = (mode != 0) || (guess > target);
  assign cmp_lt = (mode == 2) || ((mode == 0) && (guess < target));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".guess"},  guess,  0);
    checkOutput({tag, ".busy"},   busy,   0);
    checkOutput({tag, ".done"},   done,   0);
    checkOutput({tag, ".found"},  found,  0);
    checkOutput({tag, ".error"},  error,  0);
    checkOutput({tag, ".result"}, result, 0);
    checkOutput({tag, ".probes"}, probes, 0);
    checkOutput({tag, ".state"},  dut.state, IDLE);
  endtask

  // Pulse start for one edge; called at a negedge.
  task automatic applyStimulus(input logic [7:0] tgt, input int md);
    target = tgt;
    mode   = md;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Each probe holds its guess for two cycles; done rises on edge 2*n.
  task automatic runSearch(input string tag, input int n, input logic exp_found,
                           input logic exp_err, input logic [7:0] exp_result);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.guess%0d", tag, k), guess, exp_guess[k]);
      checkOutput($sformatf("%s.busy%0d", tag, k), busy, 1);
      @(negedge clk);
      checkOutput($sformatf("%s.early_done%0d", tag, k), done, 0);
    end
    @(negedge clk);
    checkOutput({tag, ".done"},   done,   1);
    checkOutput({tag, ".busy"},   busy,   0);
    checkOutput({tag, ".found"},  found,  exp_found);
    checkOutput({tag, ".error"},  error,  exp_err);
    checkOutput({tag, ".result"}, result, exp_result);
    checkOutput({tag, ".probes"}, probes, n);
    checkOutput({tag, ".guess_hold"}, guess, exp_guess[n-1]);
    @(negedge clk);
    checkOutput({tag, ".done_level"}, done, 1);
    checkOutput({tag, ".probes_hold"}, probes, n);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    target = 8'd0;
    mode   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;

    $display("[TB] target 200");
    exp_guess = '{127, 191, 223, 207, 199, 203, 201, 200, 0};
    applyStimulus(8'd200, 0);
    runSearch("t200", 8, 1'b1, 1'b0, 8'd200);

    $display("[TB] target 127, restart from DONE");
    exp_guess = '{127, 0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(8'd127, 0);
    runSearch("t127", 1, 1'b1, 1'b0, 8'd127);

    $display("[TB] target 255");
    exp_guess = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    applyStimulus(8'd255, 0);
    runSearch("t255", 9, 1'b1, 1'b0, 8'd255);

    $display("[TB] always gt");
    exp_guess = '{127, 63, 31, 15, 7, 3, 1, 0, 0};
    applyStimulus(8'd0, 1);
    runSearch("allgt", 8, 1'b0, 1'b0, 8'd0);

    $display("[TB] illegal flags, start while busy");
    applyStimulus(8'd0, 2);
    @(negedge clk);
    checkOutput("bad.guess", guess, 127);
    checkOutput("bad.busy", busy, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("bad.early_done", done, 0);
    @(negedge clk);
    checkOutput("bad.done",   done,   1);
    checkOutput("bad.error",  error,  1);
    checkOutput("bad.found",  found,  0);
    checkOutput("bad.probes", probes, 1);
    checkOutput("bad.busy_end", busy, 0);
    checkOutput("bad.result", result, 0);

    $display("[TB] reset during third probe");
    applyStimulus(8'd200, 0);
    repeat (5) @(negedge clk);
    checkOutput("midrst.guess3", guess, 223);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkIdle("midrst");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("midrst.still_idle", dut.state, IDLE);
    checkOutput("midrst.still_busy", busy, 0);

    exp_guess = '{127, 191, 223, 207, 199, 203, 201, 200, 0};
    applyStimulus(8'd200, 0);
    runSearch("after_rst", 8, 1'b1, 1'b0, 8'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
